// File: rtl/cla_pipe_if.sv
// rtl/cla_pipe_if.sv - operand/result handshake bundle for cla_pipe_adder (CLA_SUB_EN adds sub/ovf)
interface cla_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  // Operand source / result consumer side.
  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CLA_SUB_EN
    output sub,
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CLA_SUB_EN
    input  sub,
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - carry-pipelined lookahead adder, one BLK-bit slice per stage (CLA_SUB_EN adds subtract)
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input logic        clk,
  input logic        rst,
  cla_pipe_if.slave  bus
);
  localparam int STAGES = WIDTH / BLK;

  if (BLK < 1 || (WIDTH % BLK) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK");
  end

  // BLK-bit generate/propagate lookahead.
  // Returns {carry into block MSB, block carry out, block sum}.
  function automatic logic [BLK+1:0] cla_block(input logic [BLK-1:0] x,
                                               input logic [BLK-1:0] y,
                                               input logic           c0);
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           term;
    logic           pp;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    for (int i = 0; i < BLK; i++) begin
      // Carry in survives only if every lower bit propagates.
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      // Any generate at bit j whose higher bits up to i all propagate.
      for (int j = 0; j <= i; j++) begin
        pp = g[j];
        for (int k = j + 1; k <= i; k++) pp = pp & p[k];
        term = term | pp;
      end
      c[i+1] = term;
    end
    return {c[BLK-1], c[BLK], p ^ c[BLK-1:0]};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction folds into the adder as a + ~b + 1 at the pipe entry.
`ifdef CLA_SUB_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff = bus.b;
  assign c_eff = bus.cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v;
    logic             c;
    logic [WIDTH-1:0] s_r;
    logic             v_in;
    logic             ci;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_nxt;
    logic [BLK+1:0]   res;

    if (k == 0) begin : g_head
      assign v_in = bus.in_valid;
      assign ci   = c_eff;
      assign a_in = bus.a;
      assign b_in = b_eff;
      assign s_in = '0;
    end else begin : g_body
      assign v_in = g_stage[k-1].v;
      assign ci   = g_stage[k-1].c;
      assign a_in = g_stage[k-1].g_skew.a_r;
      assign b_in = g_stage[k-1].g_skew.b_r;
      assign s_in = g_stage[k-1].s_r;
    end

    assign res = cla_block(a_in[k*BLK +: BLK], b_in[k*BLK +: BLK], ci);

    // Lower slices pass through; this stage fills in its own slice.
    always_comb begin
      s_nxt                 = s_in;
      s_nxt[k*BLK +: BLK]   = res[BLK-1:0];
    end

    // Stage valid, block carry and partial sum shift together on advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v   <= 1'b0;
        c   <= 1'b0;
        s_r <= '0;
      end else if (adv) begin
        v   <= v_in;
        c   <= res[BLK];
        s_r <= s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      // Operand skew registers carry the not-yet-added upper slices.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv) begin
          a_r <= a_in;
          b_r <= b_in;
        end
      end
    end else begin : g_tail
      logic unused_tail;
      assign unused_tail = ^{a_in, b_in, res[BLK+1]};
    end
  end

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign adv          = ~g_stage[STAGES-1].v | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = g_stage[STAGES-1].v;
  assign bus.sum      = g_stage[STAGES-1].s_r;
  assign bus.cout     = g_stage[STAGES-1].c;

`ifdef CLA_SUB_EN
  logic ovf_q;
  // Signed overflow of the top slice, registered alongside the final sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= g_stage[STAGES-1].res[BLK+1] ^ g_stage[STAGES-1].res[BLK];
    end
  end
  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder (exercises CLA_SUB_EN when defined)
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  logic sub_drv;
  logic ovf_mon;

  always #5 clk = ~clk;

  cla_pipe_if #(.WIDTH(16)) bus ();

  cla_pipe_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef CLA_SUB_EN
  assign bus.sub = sub_drv;
  assign ovf_mon = bus.ovf;
`else
  assign ovf_mon = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    int          sa;
    int          sb;
    int          s;
    logic [16:0] u;
    logic        co;
    logic        ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
      s  = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      co = u[16];
      s  = sa + sb + int'(cin);
    end
    ov = (s > 32767) || (s < -32768);
    return {ov, co, u[15:0]};
  endfunction

  // Scoreboard: record accepted beats, compare every delivered result in order.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.cin, sub_drv));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got sum %0h with nothing outstanding, expected no result", bus.sum);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_result", {15'd0, bus.cout, bus.sum}, {15'd0, mon_e[16:0]});
`ifdef CLA_SUB_EN
          check("sb_ovf", {31'd0, ovf_mon}, {31'd0, mon_e[17]});
`endif
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push_beat(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub, input bit rnd);
    int t;
    bit acc;
    t = 0;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    sub_drv = sub;
    bus.in_valid = 1'b1;
    do begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, output logic [15:0] s, output logic co,
                          output logic ov, output int lat);
    bus.out_ready = 1'b1;
    push_beat(a, b, cin, sub, 1'b0);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    s  = bus.sum;
    co = bus.cout;
    ov = ovf_mon;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 40) begin
      idle(1);
      t++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          lat;
    int          got;
    int          first;

    tbl[0] = '{16'h00C0, 16'h0020, 1'b0, 16'h00E0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tbl[6] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1;
    sub_drv = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_sum", {16'd0, bus.sum}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed table: value and fixed latency.
    for (int i = 0; i < 8; i++) begin
      send_one(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, s, co, ov, lat);
      check("tbl_latency", lat, 32'd4);
      check("tbl_sum", {16'd0, s}, {16'd0, tbl[i].sum});
      check("tbl_cout", {31'd0, co}, {31'd0, tbl[i].cout});
    end

    // Back-to-back beats 1..4 -> 2,4,6,8 on consecutive cycles.
    bus.out_ready = 1'b1;
    for (int n = 1; n <= 4; n++) push_beat(16'(n), 16'(n), 1'b0, 1'b0, 1'b0);
    got = 0;
    first = -1;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("b2b_sum", {16'd0, bus.sum}, 32'(2 * (got + 1)));
        if (first < 0) first = cyc;
        check("b2b_spacing", cyc - first, got);
        got++;
      end
    end
    check("b2b_count", got, 32'd4);
    @(posedge clk);
    #1;

    // Full pipe under backpressure: frozen outputs, no accept, nothing lost.
    bus.out_ready = 1'b0;
    for (int n = 1; n <= 4; n++)
      push_beat(16'(16'h1000 * n + n), 16'h0F0F, 1'(n), 1'b0, 1'b0);
    bus.a = 16'hABCD;
    bus.b = 16'h1111;
    bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_sum", {15'd0, bus.cout, bus.sum}, {15'd0, exp_q[0][16:0]});
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    push_beat(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset with three beats in flight.
    for (int n = 1; n <= 3; n++) push_beat(16'(16'h0100 * n), 16'h00FF, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_sum", {16'd0, bus.sum}, 32'd0);
    check("midrst_cout", {31'd0, bus.cout}, 32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send_one(16'h0042, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    check("postrst_latency", lat, 32'd4);
    check("postrst_sum", {16'd0, s}, 32'h0043);

`ifdef CLA_SUB_EN
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    check("sub_sum_a", {16'd0, s}, 32'h7FFF);
    check("sub_cout_a", {31'd0, co}, 32'd1);
    check("sub_ovf_a", {31'd0, ov}, 32'd1);
    send_one(16'h0003, 16'h0005, 1'b0, 1'b1, s, co, ov, lat);
    check("sub_sum_b", {16'd0, s}, 32'hFFFE);
    check("sub_cout_b", {31'd0, co}, 32'd0);
    check("sub_ovf_b", {31'd0, ov}, 32'd0);
`endif

    // Random beats, bubbles and backpressure against the model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        idle(1);
      end
`ifdef CLA_SUB_EN
      push_beat(ra, rb, 1'($urandom), 1'($urandom), 1'b1);
`else
      push_beat(ra, rb, 1'($urandom), 1'b0, 1'b1);
`endif
    end
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
